// File: rtl/seq_mult.sv
// ============================================================================
// Module   : seq_mult (with helper nbits_adder)
// Purpose  : Radix-2 iterative signed multiplier, one N-bit add per clock,
//            start/done handshake, sign applied after magnitude multiply.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nbits_adder #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         CarryIn,
    output logic [N-1:0] sum,
    output logic         CarryOut
);
    assign {CarryOut, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, CarryIn};
endmodule

module seq_mult #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] product,
    output logic           done,
    output logic           busy
);
    localparam int            CW     = (N > 2) ? $clog2(N) : 1;
    localparam logic [N-1:0]   c_ONE  = {{(N-1){1'b0}}, 1'b1};
    localparam logic [2*N-1:0] c_ONE2 = {{(2*N-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]  c_LAST = CW'(N - 1);
    localparam logic [CW-1:0]  c_INC  = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_SIGN = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [N-1:0]     r_mcand;
    logic [N-1:0]     r_mplier;
    logic [N-1:0]     r_acc;
    logic [CW-1:0]    r_cnt;
    logic             r_neg;
    logic [2*N-1:0]   r_product;
    logic             r_done;
    logic             r_busy;

    logic [N-1:0]     w_abs_a;
    logic [N-1:0]     w_abs_b;
    logic [N-1:0]     w_addend;
    logic [N-1:0]     w_sum;
    logic             w_cout;
    logic [2*N-1:0]   w_p;

    // -2^(N-1) negates to itself, which read unsigned is exactly 2^(N-1).
    assign w_abs_a  = a[N-1] ? (~a + c_ONE) : a;
    assign w_abs_b  = b[N-1] ? (~b + c_ONE) : b;
    assign w_addend = r_mplier[0] ? r_mcand : {N{1'b0}};
    assign w_p      = {r_acc, r_mplier};

    nbits_adder #(.N(N)) u_adder (
        .a        (r_acc),
        .b        (w_addend),
        .CarryIn  (1'b0),
        .sum      (w_sum),
        .CarryOut (w_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_CALC;
            S_CALC:  if (r_cnt == c_LAST) w_next = S_SIGN;
            S_SIGN:  w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_neg     <= 1'b0;
            r_product <= '0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mcand  <= w_abs_a;
                        r_mplier <= w_abs_b;
                        r_neg    <= a[N-1] ^ b[N-1];
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                    end
                end
                S_CALC: begin
                    // Shift {carry, sum} right into {acc, mplier}.
                    r_acc    <= {w_cout, w_sum[N-1:1]};
                    r_mplier <= {w_sum[0], r_mplier[N-1:1]};
                    r_cnt    <= r_cnt + c_INC;
                end
                S_SIGN: begin
                    r_product <= r_neg ? (~w_p + c_ONE2) : w_p;
                    r_done    <= 1'b1;
                end
                S_DONE: begin
                    r_done <= 1'b0;
                    r_busy <= 1'b0;
                end
                default: begin
                    r_done <= 1'b0;
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign product = r_product;
    assign done    = r_done;
    assign busy    = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_seq_mult.sv
// ============================================================================
// Module   : tb_seq_mult
// Purpose  : Directed and swept checks of seq_mult at N=8 and N=4 against a
//            cycle-level behavioural model built from signed multiplication.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_mult;
    localparam int N8 = 8;
    localparam int N4 = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start8 = 1'b0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic [15:0] prod8;
    logic        done8;
    logic        busy8;

    logic        start4 = 1'b0;
    logic [3:0]  a4 = '0;
    logic [3:0]  b4 = '0;
    logic [7:0]  prod4;
    logic        done4;
    logic        busy4;

    int checks = 0;
    int errors = 0;
    int dn8 = 0;
    int dn4 = 0;

    seq_mult #(.N(N8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .product(prod8), .done(done8), .busy(busy8)
    );

    seq_mult #(.N(N4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
        .product(prod4), .done(done4), .busy(busy4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: an accepted op finishes with done in the (N+2)th cycle
    // after acceptance, then one cycle later the unit is idle again.
    logic        m8_act = 1'b0, m8_busy = 1'b0, m8_done = 1'b0;
    int          m8_ph = 0, m8_ops = 0;
    logic [15:0] m8_pend = '0, m8_prod = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m8_act <= 1'b0; m8_busy <= 1'b0; m8_done <= 1'b0;
            m8_ph <= 0; m8_prod <= '0; m8_pend <= '0;
        end else if (m8_act) begin
            m8_ph <= m8_ph + 1;
            if (m8_ph == N8) begin
                m8_prod <= m8_pend;
                m8_done <= 1'b1;
            end else if (m8_ph == N8 + 1) begin
                m8_act <= 1'b0; m8_busy <= 1'b0; m8_done <= 1'b0;
            end
        end else if (start8) begin
            m8_act  <= 1'b1;
            m8_busy <= 1'b1;
            m8_ph   <= 0;
            m8_pend <= $signed(a8) * $signed(b8);
            m8_ops  <= m8_ops + 1;
        end
    end

    logic        m4_act = 1'b0, m4_busy = 1'b0, m4_done = 1'b0;
    int          m4_ph = 0, m4_ops = 0;
    logic [7:0]  m4_pend = '0, m4_prod = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m4_act <= 1'b0; m4_busy <= 1'b0; m4_done <= 1'b0;
            m4_ph <= 0; m4_prod <= '0; m4_pend <= '0;
        end else if (m4_act) begin
            m4_ph <= m4_ph + 1;
            if (m4_ph == N4) begin
                m4_prod <= m4_pend;
                m4_done <= 1'b1;
            end else if (m4_ph == N4 + 1) begin
                m4_act <= 1'b0; m4_busy <= 1'b0; m4_done <= 1'b0;
            end
        end else if (start4) begin
            m4_act  <= 1'b1;
            m4_busy <= 1'b1;
            m4_ph   <= 0;
            m4_pend <= $signed(a4) * $signed(b4);
            m4_ops  <= m4_ops + 1;
        end
    end

    always @(posedge clk) begin
        #1;
        chk("cycle8 {done,busy,product}", {14'd0, done8, busy8, prod8},
            {14'd0, m8_done, m8_busy, m8_prod});
        chk("cycle4 {done,busy,product}", {22'd0, done4, busy4, prod4},
            {22'd0, m4_done, m4_busy, m4_prod});
        if (done8) dn8++;
        if (done4) dn4++;
    end

    // One N=8 operation; inj>0 re-pulses start with other operands in that cycle.
    task automatic run8(input logic [7:0] ta, input logic [7:0] tb_v,
                        input logic [15:0] exp, input string nm, input int inj);
        int idx;
        int busycnt;
        int dn_before;
        @(negedge clk);
        a8 = ta; b8 = tb_v; start8 = 1'b1;
        @(posedge clk); #1;
        dn_before = dn8;
        idx = 1;
        busycnt = busy8 ? 1 : 0;
        while (idx < 40 && !done8) begin
            @(negedge clk);
            start8 = (idx == inj);
            if (idx == inj) begin
                a8 = 8'd99; b8 = 8'd99;
            end
            @(posedge clk); #1;
            idx++;
            if (busy8) busycnt++;
        end
        chk({nm, " done cycle"}, idx, N8 + 2);
        chk({nm, " product"}, {16'd0, prod8}, {16'd0, exp});
        chk({nm, " busy cycles"}, busycnt, N8 + 2);
        @(negedge clk);
        start8 = 1'b0;
        repeat (14) @(posedge clk);
        #2;
        chk({nm, " done pulses"}, dn8 - dn_before, 1);
        chk({nm, " idle busy"}, {31'd0, busy8}, 0);
    endtask

    initial begin
        logic [7:0] iv;
        int ops0;
        int dnb;

        repeat (3) @(negedge clk);
        chk("reset product8", {16'd0, prod8}, 0);
        chk("reset done/busy8", {30'd0, done8, busy8}, 0);
        chk("reset product4", {24'd0, prod4}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run8(8'd7,    8'd6,    16'd42,    "7*6",       0);
        run8(8'h80,   8'h80,   16'h4000,  "-128*-128", 0);
        run8(8'h80,   8'd127,  16'hC080,  "-128*127",  0);
        run8(8'd0,    8'hB3,   16'h0000,  "0*-77",     0);
        run8(8'd13,   8'd5,    16'd65,    "13*5 inj",  3);
        run8(8'hFB,   8'd3,    16'hFFF1,  "-5*3",      0);

        // Asynchronous reset in the middle of CALC.
        @(negedge clk);
        a8 = 8'd50; b8 = 8'd3; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async rst product", {16'd0, prod8}, 0);
        chk("async rst done/busy", {30'd0, done8, busy8}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run8(8'd12, 8'hF4, 16'hFF70, "12*-12", 0);

        // N=4 exhaustive sweep with start held high.
        ops0 = m4_ops; dnb = dn4;
        @(negedge clk);
        a4 = 4'd0; b4 = 4'd0; start4 = 1'b1;
        for (int i = 0; i < 256; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i < 255) begin
                iv = 8'(i + 1);
                a4 = iv[7:4]; b4 = iv[3:0];
            end else begin
                start4 = 1'b0;
            end
            repeat (N4 + 2) @(posedge clk);
        end
        repeat (12) @(posedge clk);
        #2;
        chk("sweep4 ops accepted", m4_ops - ops0, 256);
        chk("sweep4 done pulses", dn4 - dnb, 256);

        // N=8 random sweep with start held high.
        ops0 = m8_ops; dnb = dn8;
        @(negedge clk);
        a8 = 8'($urandom); b8 = 8'($urandom); start8 = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i < 999) begin
                a8 = 8'($urandom); b8 = 8'($urandom);
            end else begin
                start8 = 1'b0;
            end
            repeat (N8 + 2) @(posedge clk);
        end
        repeat (15) @(posedge clk);
        #2;
        chk("sweep8 ops accepted", m8_ops - ops0, 1000);
        chk("sweep8 done pulses", dn8 - dnb, 1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
